// File: rtl/timestamp_capture.sv
// Multi-channel event timestamp capture: rising edges latch the running timestamp
// per channel, and a priority arbiter drains pending captures into a shared FIFO.
module timestamp_capture #(
  parameter  int TIMESTAMP_WIDTH = 64,
  parameter  int NUM_CHANNELS    = 4,
  parameter  int FIFO_DEPTH_LOG2 = 4,
  localparam int CH_W            = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [TIMESTAMP_WIDTH-1:0] timestamp_in,
  input  logic [NUM_CHANNELS-1:0]    event_in,
  input  logic [NUM_CHANNELS-1:0]    channel_enable,
  output logic                       ts_valid,
  input  logic                       ts_ready,
  output logic [TIMESTAMP_WIDTH-1:0] ts_data,
  output logic [CH_W-1:0]            ts_channel,
  output logic                       ts_lost,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic [NUM_CHANNELS-1:0]    overflow,
  input  logic [NUM_CHANNELS-1:0]    overflow_clear
);

  localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam int ENTRY_W = TIMESTAMP_WIDTH + CH_W + 1;
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_LVL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  logic [NUM_CHANNELS-1:0]    event_d;
  logic [NUM_CHANNELS-1:0]    pending;
  logic [NUM_CHANNELS-1:0]    lost_flag;
  logic [TIMESTAMP_WIDTH-1:0] hold [NUM_CHANNELS];

  logic [ENTRY_W-1:0]         mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;

  logic [NUM_CHANNELS-1:0]    capture;
  logic [NUM_CHANNELS-1:0]    drain;
  logic [NUM_CHANNELS-1:0]    drop;
  logic [CH_W-1:0]            sel;
  logic [TIMESTAMP_WIDTH-1:0] sel_ts;
  logic                       sel_lost;
  logic                       sel_valid;
  logic                       full;
  logic                       wr_en;
  logic                       pop;
  logic [ENTRY_W-1:0]         head;

  // Descending scan so the lowest pending channel is the last one to win.
  always_comb begin
    capture   = event_in & ~event_d & channel_enable;
    sel       = '0;
    sel_ts    = '0;
    sel_lost  = 1'b0;
    sel_valid = 1'b0;
    for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
      if (pending[c]) begin
        sel       = CH_W'(c);
        sel_ts    = hold[c];
        sel_lost  = lost_flag[c];
        sel_valid = 1'b1;
      end
    end
    full  = (fifo_level == DEPTH_LVL);
    wr_en = sel_valid && !full;
    pop   = ts_valid && ts_ready;
    drain = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      drain[c] = wr_en && (sel == CH_W'(c));
    end
    drop = capture & pending & ~drain;
  end

  // A capture in the same cycle its channel drains is latched, not dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_d    <= '1;
      pending    <= '0;
      lost_flag  <= '0;
      overflow   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        hold[c] <= '0;
      end
    end else begin
      event_d  <= event_in;
      overflow <= (overflow & ~overflow_clear) | drop;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (drop[c]) begin
          lost_flag[c] <= 1'b1;
        end else if (capture[c]) begin
          hold[c]    <= timestamp_in;
          pending[c] <= 1'b1;
          if (drain[c]) begin
            lost_flag[c] <= 1'b0;
          end
        end else if (drain[c]) begin
          pending[c]   <= 1'b0;
          lost_flag[c] <= 1'b0;
        end
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {sel_lost, sel, sel_ts};
    end
  end

  // Storage is never cleared, so the head is masked to read zero whenever empty.
  assign head       = mem[rd_ptr];
  assign ts_valid   = (fifo_level != '0);
  assign ts_data    = ts_valid ? head[TIMESTAMP_WIDTH-1:0] : '0;
  assign ts_channel = ts_valid ? head[TIMESTAMP_WIDTH +: CH_W] : '0;
  assign ts_lost    = ts_valid ? head[ENTRY_W-1] : 1'b0;

endmodule

// File: doc/timestamp_capture.md
TIMESTAMP_CAPTURE -- requirements
Module: timestamp_capture

Interface
REQ-001 SHALL have parameter TIMESTAMP_WIDTH, default 64: width of captured timestamp.
REQ-002 SHALL have parameter NUM_CHANNELS, default 4, legal range 1..16: number of event inputs.
REQ-003 SHALL have parameter FIFO_DEPTH_LOG2, default 4: FIFO holds 2**FIFO_DEPTH_LOG2 entries.
REQ-004 SHALL derive CH_W = max(1, clog2(NUM_CHANNELS)).
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port timestamp_in, input, TIMESTAMP_WIDTH: free-running timestamp, synchronous to clk.
REQ-008 SHALL have port event_in, input, NUM_CHANNELS: event levels, already synchronous to clk.
REQ-009 SHALL have port channel_enable, input, NUM_CHANNELS: per-channel capture enable.
REQ-010 SHALL have port ts_valid, output, 1: FIFO head entry available.
REQ-011 SHALL have port ts_ready, input, 1: consumer accepts head entry.
REQ-012 SHALL have port ts_data, output, TIMESTAMP_WIDTH: head entry timestamp.
REQ-013 SHALL have port ts_channel, output, CH_W: head entry channel index.
REQ-014 SHALL have port ts_lost, output, 1: at least one capture on that channel was dropped before this entry.
REQ-015 SHALL have port fifo_level, output, FIFO_DEPTH_LOG2+1: number of stored entries.
REQ-016 SHALL have port overflow, output, NUM_CHANNELS: sticky per-channel drop flags.
REQ-017 SHALL have port overflow_clear, input, NUM_CHANNELS: per-bit clear of overflow.

Function
REQ-018 Edge detect: channel c SHALL register a capture at clock edge k when event_in[c]=1, the previous sample event_d[c]=0, and channel_enable[c]=1.
REQ-019 On capture, channel c SHALL latch the timestamp_in value sampled at edge k into its holding register and set pending[c].
REQ-020 If a capture occurs on channel c while pending[c]=1, the new timestamp SHALL be discarded, the held value retained, lost_flag[c] set, and overflow[c] set.
REQ-021 Each cycle, the lowest-index channel with pending=1 SHALL be written to the FIFO if fifo_level < depth; its pending bit SHALL clear and its lost_flag SHALL travel as ts_lost, then clear.
REQ-022 A FIFO write SHALL use fifo_level before any same-cycle pop: when the FIFO is full, no write occurs even if ts_ready=1.
REQ-023 A pending bit SHALL clear and a capture on the same channel SHALL occur in the same cycle without loss: the new value is latched and pending stays 1.
REQ-024 Minimum latency SHALL be 2 clocks: capture at edge k, FIFO write at edge k+1, ts_valid=1 after edge k+1.
REQ-025 ts_valid SHALL equal (fifo_level != 0); ts_data, ts_channel, and ts_lost SHALL reflect the head entry and remain stable while ts_valid=1 and ts_ready=0.
REQ-026 A pop SHALL occur at an edge where ts_valid=1 and ts_ready=1; ts_ready while empty SHALL be ignored.
REQ-027 fifo_level SHALL increment on write-only cycles, decrement on pop-only cycles, and be unchanged when a write and a pop occur together.
REQ-028 Read and write pointers SHALL wrap modulo depth.
REQ-029 channel_enable deassertion SHALL block new captures only; an already pending entry SHALL still drain.
REQ-030 overflow_clear[c]=1 SHALL clear overflow[c] unless a drop on c occurs in the same cycle, in which case set wins.

Reset
REQ-031 reset_n=0 SHALL asynchronously clear: ts_valid=0, fifo_level=0, pointers=0, pending=0, lost_flag=0, overflow=0.
REQ-032 During reset, event_d SHALL be all ones, so an input already high at release is not an edge.
REQ-033 ts_data, ts_channel, and ts_lost SHALL read 0 during reset; FIFO storage need not be cleared.
REQ-034 Reset mid-operation SHALL discard all stored and pending entries; the first capture after release SHALL behave as if from an empty state.

Verification
REQ-035 Single event: channel 2 rises when timestamp_in=0x100 -> after 2 clocks ts_valid=1, ts_data=0x100, ts_channel=2, ts_lost=0, fifo_level=1.
REQ-036 Simultaneous events: channels 0, 1, and 3 rise at ts=0x200 -> entries are popped in order ch0, ch1, ch3, all with ts_data=0x200, on consecutive cycles with ts_ready=1.
REQ-037 Full FIFO: 16 entries with ts_ready=0 and channel 0 rising twice more -> fifo_level stays 16, overflow[0]=1; after one pop, the held first value is written with ts_lost=1.
REQ-038 Wrap and concurrency: stream 40 events with ts_ready toggling -> all timestamps arrive in order, fifo_level never exceeds 16, and level is unchanged on simultaneous write and pop.
REQ-039 Reset: assert reset_n=0 with fifo_level=5 and event_in held high -> outputs go to 0 immediately; after release, no capture occurs until event_in falls and rises again.
REQ-040 Enable and clear: channel_enable[1]=0 with edges on channel 1 -> no entries; overflow_clear[0] pulse -> overflow[0]=0 next cycle.
